fifo_bank_refill: RTL and testbench

Refill controller directly downstream of the per-flow FIFO bank. When the PIFO consumes a flow's head element, it sends a refill request here. This block pops that flow's next element from the bank and forwards it to the PIFO insert port over a valid/ready handshake. Requests are buffered in a small queue, so the PIFO never stalls on bank access.

---
 rtl/fifo_bank_refill_pkg.sv | 19 +
 rtl/fifo_bank_refill_fifo.sv | 61 ++++++
 rtl/fifo_bank_refill.sv | 122 ++++++++++++
 tb/tb_fifo_bank_refill.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_bank_refill_pkg.sv
// Shared definitions for the refill controller and the per-flow FIFO bank.
// Holds the controller state encoding, the miss counter width and the flow-id
// width derivation. The bank uses the same derivation so both sides agree.
package fifo_bank_refill_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_SEND   = 2'd2
  } state_e;

  localparam int unsigned MISS_WIDTH = 16;

  // Flow id width: one code beyond the last flow is kept representable.
  function automatic int unsigned idx_width(input int unsigned num_flows);
    return $clog2(num_flows + 1);
  endfunction

endpackage

// File: rtl/fifo_bank_refill_fifo.sv
// Small synchronous FIFO used as the refill request queue.
// Ports: clk, rst_n (async active-low), data_in/data_in_valid/data_in_ready
// (enqueue side), data_out/data_out_valid/data_out_ready (dequeue side).
// data_in_ready is derived from the registered occupancy only, so an entry
// freed by a dequeue is not reusable until the following cycle.
module fifo #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned DEPTH         = 4,
  parameter bit          BYPASS_ENABLE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ready
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  empty;
  logic                  bypass;
  logic                  push;
  logic                  pop;

  assign empty          = (count == '0);
  assign bypass         = BYPASS_ENABLE && empty;
  assign data_in_ready  = (count != CNT_W'(DEPTH));
  assign data_out_valid = bypass ? data_in_valid : !empty;
  assign data_out       = bypass ? data_in : mem[rd_ptr];

  // In bypass, an element consumed straight through never lands in storage.
  assign push = data_in_valid && data_in_ready && !(bypass && data_out_ready);
  assign pop  = data_out_ready && !empty;

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset; occupancy qualifies every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/fifo_bank_refill.sv
// Refill controller between the PIFO and the per-flow FIFO bank.
// Queues refill requests, pops the requested flow's head from the bank and
// offers it to the PIFO insert port; empty flows are counted as misses.
// Ports: clk, reset (async active-low); i__refill_* / o__refill_ready request
// side; o__bank_pop_flow_id, o__bank_pop, i__bank_pop_valid, i__bank_pop_data
// bank side; o__insert_* / i__insert_ready PIFO side; o__miss_count, o__idle.
module fifo_bank_refill
  import fifo_bank_refill_pkg::*;
#(
  parameter  int unsigned NUM_FLOWS  = 16,
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned REQ_DEPTH  = 4,
  localparam int unsigned IDX_WIDTH  = idx_width(NUM_FLOWS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i__refill_valid,
  input  logic [IDX_WIDTH-1:0]  i__refill_flow_id,
  output logic                  o__refill_ready,
  output logic [IDX_WIDTH-1:0]  o__bank_pop_flow_id,
  output logic                  o__bank_pop,
  input  logic                  i__bank_pop_valid,
  input  logic [DATA_WIDTH-1:0] i__bank_pop_data,
  output logic                  o__insert_valid,
  output logic [IDX_WIDTH-1:0]  o__insert_flow_id,
  output logic [DATA_WIDTH-1:0] o__insert_data,
  input  logic                  i__insert_ready,
  output logic [MISS_WIDTH-1:0] o__miss_count,
  output logic                  o__idle
);

  state_e                 state_q, state_d;
  logic [IDX_WIDTH-1:0]   flow_q, flow_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [MISS_WIDTH-1:0]  miss_q, miss_d;
  logic                   q_valid;
  logic [IDX_WIDTH-1:0]   q_data;
  logic                   deq;
  logic                   pop_c;

  // Request queue; no bypass so a request always spends a cycle queued.
  fifo #(
    .DATA_WIDTH    (IDX_WIDTH),
    .DEPTH         (REQ_DEPTH),
    .BYPASS_ENABLE (1'b0)
  ) u_req_q (
    .clk            (clk),
    .rst_n          (reset),
    .data_in        (i__refill_flow_id),
    .data_in_valid  (i__refill_valid),
    .data_in_ready  (o__refill_ready),
    .data_out       (q_data),
    .data_out_valid (q_valid),
    .data_out_ready (deq)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      flow_q  <= '0;
      data_q  <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      flow_q  <= flow_d;
      data_q  <= data_d;
      miss_q  <= miss_d;
    end
  end

  // Next-state, dequeue and bank pop.
  always_comb begin
    state_d = state_q;
    flow_d  = flow_q;
    data_d  = data_q;
    miss_d  = miss_q;
    deq     = 1'b0;
    pop_c   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (q_valid) begin
          deq     = 1'b1;
          flow_d  = q_data;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (i__bank_pop_valid) begin
          pop_c   = 1'b1;
          data_d  = i__bank_pop_data;
          state_d = ST_SEND;
        end else begin
          if (miss_q != '1) miss_d = miss_q + MISS_WIDTH'(1);
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        // Chaining straight into LOOKUP gives one element every two cycles.
        if (i__insert_ready) begin
          if (q_valid) begin
            deq     = 1'b1;
            flow_d  = q_data;
            state_d = ST_LOOKUP;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o__bank_pop_flow_id = flow_q;
  assign o__bank_pop         = pop_c;
  assign o__insert_valid     = (state_q == ST_SEND);
  assign o__insert_flow_id   = flow_q;
  assign o__insert_data      = data_q;
  assign o__miss_count       = miss_q;
  assign o__idle             = (state_q == ST_IDLE) && !q_valid;

endmodule

// File: tb/tb_fifo_bank_refill.sv
// Scoreboard bench for fifo_bank_refill. A behavioural bank (per-flow queues)
// decides at request acceptance whether the request yields an element or a
// miss; a monitor pops expectations on every insert handshake.
module tb_fifo_bank_refill;

  localparam int unsigned IDX_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             i__refill_valid;
  logic [IDX_W-1:0] i__refill_flow_id;
  logic             o__refill_ready;
  logic [IDX_W-1:0] o__bank_pop_flow_id;
  logic             o__bank_pop;
  logic             i__bank_pop_valid;
  logic [7:0]       i__bank_pop_data;
  logic             o__insert_valid;
  logic [IDX_W-1:0] o__insert_flow_id;
  logic [7:0]       o__insert_data;
  logic             i__insert_ready = 1'b1;
  logic [15:0]      o__miss_count;
  logic             o__idle;

  always #5 clk = ~clk;

  fifo_bank_refill #(
    .NUM_FLOWS  (16),
    .DATA_WIDTH (8),
    .REQ_DEPTH  (4)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .i__refill_valid     (i__refill_valid),
    .i__refill_flow_id   (i__refill_flow_id),
    .o__refill_ready     (o__refill_ready),
    .o__bank_pop_flow_id (o__bank_pop_flow_id),
    .o__bank_pop         (o__bank_pop),
    .i__bank_pop_valid   (i__bank_pop_valid),
    .i__bank_pop_data    (i__bank_pop_data),
    .o__insert_valid     (o__insert_valid),
    .o__insert_flow_id   (o__insert_flow_id),
    .o__insert_data      (o__insert_data),
    .i__insert_ready     (i__insert_ready),
    .o__miss_count       (o__miss_count),
    .o__idle             (o__idle)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int ready_mode = 0;   // 0: always ready, 1: random, 2: stalled

  // Bank storage: stimulus writes wr/bmem, the pop process advances rd.
  logic [7:0] bmem [16][256];
  int         wr [16];
  int         rd [16];
  int         pop_cnt = 0;
  int         last_pop_flow = -1;
  logic [3:0] bsel;

  // Reference model: per-flow contents and expected inserts.
  int mbank [16][$];
  int exp_flow [$];
  int exp_data [$];
  int hs_log [$];
  int miss_exp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  assign bsel             = o__bank_pop_flow_id[3:0];
  assign i__bank_pop_valid = (wr[bsel] != rd[bsel]);
  assign i__bank_pop_data  = bmem[bsel][rd[bsel] % 256];

  always @(posedge clk) begin
    if (o__bank_pop) begin
      rd[bsel]      <= rd[bsel] + 1;
      pop_cnt       <= pop_cnt + 1;
      last_pop_flow <= int'(o__bank_pop_flow_id);
    end
  end

  always @(negedge clk) begin
    case (ready_mode)
      0:       i__insert_ready = 1'b1;
      1:       i__insert_ready = 1'($urandom_range(0, 1));
      default: i__insert_ready = 1'b0;
    endcase
  end

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: insert handshakes against the scoreboard, plus hold stability.
  logic       held = 1'b0;
  logic [4:0] held_flow;
  logic [7:0] held_data;
  int         ef, ed;
  always @(negedge clk) begin
    #1;
    if (!reset) begin
      held = 1'b0;
    end else begin
      if (o__bank_pop) check("pop_only_nonempty", longint'(i__bank_pop_valid), 1);
      if (held) begin
        check("hold_valid", longint'(o__insert_valid), 1);
        check("hold_flow", longint'(o__insert_flow_id), longint'(held_flow));
        check("hold_data", longint'(o__insert_data), longint'(held_data));
      end
      if (o__insert_valid && i__insert_ready) begin
        hs_log.push_back(cyc);
        if (exp_flow.size() == 0) begin
          check("unexpected_insert", longint'(o__insert_flow_id), -1);
        end else begin
          ef = exp_flow.pop_front();
          ed = exp_data.pop_front();
          check("insert_flow", longint'(o__insert_flow_id), longint'(ef));
          check("insert_data", longint'(o__insert_data), longint'(ed));
        end
      end
      held      = o__insert_valid && !i__insert_ready;
      held_flow = o__insert_flow_id;
      held_data = o__insert_data;
    end
  end

  task automatic bank_push(input int f, input int d);
    bmem[f][wr[f] % 256] = 8'(d);
    wr[f] = wr[f] + 1;
    mbank[f].push_back(d);
  endtask

  // A request either takes the flow's current head or is a saturating miss.
  task automatic model_accept(input int f);
    if (mbank[f].size() > 0) begin
      exp_flow.push_back(f);
      exp_data.push_back(mbank[f].pop_front());
    end else if (miss_exp < 65535) begin
      miss_exp++;
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_req(input int f);
    int n;
    n = 0;
    i__refill_valid   = 1'b1;
    i__refill_flow_id = IDX_W'(f);
    while (!o__refill_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!o__refill_ready) begin
      check("req_accept_timeout", longint'(o__refill_ready), 1);
      i__refill_valid = 1'b0;
    end else begin
      model_accept(f);
      @(negedge clk);
      acc_cyc = cyc;
      i__refill_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!(o__idle && exp_flow.size() == 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain"}, longint'(o__idle && exp_flow.size() == 0), 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, n;
    reset             = 1'b0;
    i__refill_valid   = 1'b0;
    i__refill_flow_id = '0;
    #1;
    check("rst_insert_valid", longint'(o__insert_valid), 0);
    check("rst_bank_pop", longint'(o__bank_pop), 0);
    check("rst_miss", longint'(o__miss_count), 0);
    check("rst_idle", longint'(o__idle), 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_ready", longint'(o__refill_ready), 1);

    // Single refill and its latency.
    bank_push(3, 'h12);
    bank_push(3, 'h34);
    p0 = pop_cnt;
    send_req(3);
    n = 0;
    while (!o__insert_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    // Accepted at edge N: LOOKUP after edge N+1, insert_valid after edge N+2.
    check("single_latency", longint'(cyc - acc_cyc), 2);
    wait_idle("single");
    check("single_pops", longint'(pop_cnt - p0), 1);
    check("single_pop_flow", longint'(last_pop_flow), 3);
    check("single_left", longint'(wr[3] - rd[3]), 1);
    check("single_head", longint'(bmem[3][rd[3] % 256]), 'h34);

    // Empty flow: miss, no pop.
    p0 = pop_cnt;
    send_req(5);
    wait_idle("empty");
    check("empty_pops", longint'(pop_cnt - p0), 0);
    check("empty_miss", longint'(o__miss_count), longint'(miss_exp));

    // Backpressure: queue fills, SEND holds, then drains at one per 2 cycles.
    ready_mode = 2;
    @(negedge clk);
    for (int f = 1; f <= 5; f++) bank_push(f, 'h40 + f);
    for (int f = 1; f <= 5; f++) send_req(f);
    check("bp_ready_full", longint'(o__refill_ready), 0);
    repeat (10) @(negedge clk);
    check("bp_held_valid", longint'(o__insert_valid), 1);
    check("bp_held_flow", longint'(o__insert_flow_id), 1);
    hs_log.delete();
    ready_mode = 0;
    wait_idle("bp");
    check("bp_insert_count", longint'(hs_log.size()), 5);
    for (int k = 1; k < hs_log.size(); k++)
      check("bp_spacing", longint'(hs_log[k] - hs_log[k-1]), 2);

    // Duplicate requests for one flow; the third finds it empty.
    bank_push(7, 'hA0);
    bank_push(7, 'hA1);
    send_req(7);
    send_req(7);
    send_req(7);
    wait_idle("dup");
    check("dup_miss", longint'(o__miss_count), longint'(miss_exp));

    // Randomised rounds with random PIFO backpressure.
    ready_mode = 1;
    for (int r = 0; r < 25; r++) begin
      n = $urandom_range(0, 6);
      for (int k = 0; k < n; k++) bank_push($urandom_range(0, 7), $urandom_range(0, 255));
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) send_req($urandom_range(0, 7));
      wait_idle("rand");
      check("rand_miss", longint'(o__miss_count), longint'(miss_exp));
    end

    // Reset while an element sits in SEND: it is lost, everything clears.
    ready_mode = 2;
    @(negedge clk);
    bank_push(9, 'h99);
    send_req(9);
    n = 0;
    while (!o__insert_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rsend_in_send", longint'(o__insert_valid), 1);
    reset = 1'b0;
    #1;
    check("rsend_insert_valid", longint'(o__insert_valid), 0);
    check("rsend_bank_pop", longint'(o__bank_pop), 0);
    check("rsend_miss", longint'(o__miss_count), 0);
    check("rsend_idle", longint'(o__idle), 1);
    exp_flow.delete();
    exp_data.delete();
    miss_exp = 0;
    ready_mode = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rsend_ready_after", longint'(o__refill_ready), 1);
    check("rsend_idle_after", longint'(o__idle), 1);

    // Saturation: preload the counter near the top, then keep missing.
    force dut.miss_q = 16'hFFFC;
    @(negedge clk);
    release dut.miss_q;
    miss_exp = 65532;
    send_req(15);
    send_req(15);
    wait_idle("sat_a");
    check("sat_near", longint'(o__miss_count), longint'(miss_exp));
    for (int k = 0; k < 4; k++) send_req(15);
    wait_idle("sat_b");
    check("sat_top", longint'(o__miss_count), 65535);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
